block_memory_controller: RTL and testbench

- Sits directly downstream of the 1 KB direct-mapped write-back cache. It consumes the cache's 256-bit block-level miss/writeback requests and serialises them into 8 single-word (32-bit) beats to a synchronous word SRAM.
- Provides a programmable access latency, so cache miss penalties are realistic and visible in simulation.
- Returns a one-cycle mem_ready completion pulse. For reads, it holds the assembled block stable on mem_rdata.

---
 rtl/block_memory_controller_if.sv | 29 ++
 rtl/block_memory_controller.sv | 161 ++++++++++++++++
 tb/tb_block_memory_controller.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/block_memory_controller_if.sv
// Cache-side block bus plus SRAM word port for block_memory_controller.
// master: the cache/SRAM environment; slave: the controller.
interface block_memory_controller_if #(parameter int ADDR_W = 10);
   logic [31:0]       mem_addr;
   logic [255:0]      mem_wdata;
   logic              mem_read;
   logic              mem_write;
   logic [255:0]      mem_rdata;
   logic              mem_ready;
   logic              busy;
   logic              proto_err;
   logic              sram_en;
   logic              sram_we;
   logic [ADDR_W-1:0] sram_addr;
   logic [31:0]       sram_wdata;
   logic [31:0]       sram_rdata;

   modport master (
      output mem_addr, mem_wdata, mem_read, mem_write, sram_rdata,
      input  mem_rdata, mem_ready, busy, proto_err,
             sram_en, sram_we, sram_addr, sram_wdata
   );

   modport slave (
      input  mem_addr, mem_wdata, mem_read, mem_write, sram_rdata,
      output mem_rdata, mem_ready, busy, proto_err,
             sram_en, sram_we, sram_addr, sram_wdata
   );
endinterface

// File: rtl/block_memory_controller.sv
// Block memory controller: serialises 256-bit cache block reads/writes into
// 8 word beats on a synchronous SRAM, after LATENCY idle wait cycles.
// Optional feature macro MEMCTRL_STATS_EN adds saturating rd_count/wr_count.
module block_memory_controller #(
   parameter int LATENCY = 4,
   parameter int ADDR_W  = 10
) (
   input logic clk,
   input logic rst_n,
   block_memory_controller_if.slave bus
`ifdef MEMCTRL_STATS_EN
   , output logic [15:0] rd_count
   , output logic [15:0] wr_count
`endif
);

   typedef enum logic [2:0] {IDLE, LAT, XFER, DRAIN, DONE} state_t;

   localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [LW-1:0] LAT_LAST = LW'((LATENCY > 0) ? LATENCY - 1 : 0);

   state_t            state_q, state_d;
   logic [LW-1:0]     lat_cnt_q, lat_cnt_d;
   logic [2:0]        beat_q, beat_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [255:0]      wbuf_q, wbuf_d;
   logic              op_wr_q, op_wr_d;
   logic              proto_err_q, proto_err_d;
   logic              cap_vld_q, cap_vld_d;
   logic [2:0]        cap_idx_q, cap_idx_d;
   logic [255:0]      mem_rdata_q, mem_rdata_d;

   logic              sram_en, sram_we, mem_ready;
   logic [31:0]       sram_wdata;
   logic [ADDR_W-1:0] sram_addr;

   // Byte offset and bits above the SRAM range do not affect addressing.
   logic unused_addr;
   assign unused_addr = ^{bus.mem_addr[31:ADDR_W+5], bus.mem_addr[4:0]};

   // Next-state, datapath and SRAM drive; capture of the previous read beat.
   always_comb begin
      state_d     = state_q;
      lat_cnt_d   = lat_cnt_q;
      beat_d      = beat_q;
      base_d      = base_q;
      wbuf_d      = wbuf_q;
      op_wr_d     = op_wr_q;
      proto_err_d = proto_err_q;
      cap_vld_d   = 1'b0;
      cap_idx_d   = beat_q;
      mem_rdata_d = mem_rdata_q;
      sram_en     = 1'b0;
      sram_we     = 1'b0;
      sram_addr   = '0;
      sram_wdata  = '0;
      mem_ready   = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.mem_read || bus.mem_write) begin
               base_d    = bus.mem_addr[ADDR_W+4:5];
               wbuf_d    = bus.mem_wdata;
               op_wr_d   = bus.mem_write;   // write wins a collision
               lat_cnt_d = '0;
               beat_d    = '0;
               if (bus.mem_read && bus.mem_write) proto_err_d = 1'b1;
               state_d   = (LATENCY > 0) ? LAT : XFER;
            end
         end
         LAT: begin
            lat_cnt_d = lat_cnt_q + LW'(1);
            if (lat_cnt_q == LAT_LAST) state_d = XFER;
         end
         XFER: begin
            sram_en   = 1'b1;
            sram_we   = op_wr_q;
            // {base,k} truncated: blocks beyond the SRAM alias by wrap-around
            sram_addr = ADDR_W'({base_q, beat_q});
            if (op_wr_q) sram_wdata = wbuf_q[{beat_q, 5'd0} +: 32];
            cap_vld_d = !op_wr_q;
            beat_d    = beat_q + 3'd1;
            if (beat_q == 3'd7) state_d = op_wr_q ? DONE : DRAIN;
         end
         DRAIN: state_d = DONE;
         DONE: begin
            mem_ready = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // SRAM data for beat k arrives one cycle after its access
      if (cap_vld_q) mem_rdata_d[{cap_idx_q, 5'd0} +: 32] = bus.sram_rdata;
   end

   // State and datapath registers; reset aborts any transfer in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         lat_cnt_q   <= '0;
         beat_q      <= '0;
         base_q      <= '0;
         wbuf_q      <= '0;
         op_wr_q     <= 1'b0;
         proto_err_q <= 1'b0;
         cap_vld_q   <= 1'b0;
         cap_idx_q   <= '0;
         mem_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         lat_cnt_q   <= lat_cnt_d;
         beat_q      <= beat_d;
         base_q      <= base_d;
         wbuf_q      <= wbuf_d;
         op_wr_q     <= op_wr_d;
         proto_err_q <= proto_err_d;
         cap_vld_q   <= cap_vld_d;
         cap_idx_q   <= cap_idx_d;
         mem_rdata_q <= mem_rdata_d;
      end
   end

   assign bus.sram_en    = sram_en;
   assign bus.sram_we    = sram_we;
   assign bus.sram_addr  = sram_addr;
   assign bus.sram_wdata = sram_wdata;
   assign bus.mem_ready  = mem_ready;
   assign bus.mem_rdata  = mem_rdata_q;
   assign bus.busy       = (state_q != IDLE);
   assign bus.proto_err  = proto_err_q;

`ifdef MEMCTRL_STATS_EN
   logic [15:0] rd_count_q, rd_count_d, wr_count_q, wr_count_d;

   // Count completed transfers on their DONE cycle, saturating.
   always_comb begin
      rd_count_d = rd_count_q;
      wr_count_d = wr_count_q;
      if (state_q == DONE) begin
         if (op_wr_q && wr_count_q != 16'hFFFF)  wr_count_d = wr_count_q + 16'd1;
         if (!op_wr_q && rd_count_q != 16'hFFFF) rd_count_d = rd_count_q + 16'd1;
      end
   end

   // Statistics registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_count_q <= '0;
         wr_count_q <= '0;
      end else begin
         rd_count_q <= rd_count_d;
         wr_count_q <= wr_count_d;
      end
   end

   assign rd_count = rd_count_q;
   assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_block_memory_controller.sv
// Self-checking bench for block_memory_controller: directed table, LATENCY=0
// timing sequence, reset-abort sequence, then random transfers vs a word model.
module tb_block_memory_controller;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   block_memory_controller_if #(.ADDR_W(10)) if0 ();
   block_memory_controller_if #(.ADDR_W(10)) if1 ();

   block_memory_controller #(.LATENCY(4), .ADDR_W(10)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
   block_memory_controller #(.LATENCY(0), .ADDR_W(10)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

   // Synchronous word SRAMs behind each controller
   logic [31:0] sram0 [1024];
   logic [31:0] sram1 [1024];
   logic [31:0] rd0, rd1;
   always @(posedge clk) begin
      if (if0.sram_en) begin
         if (if0.sram_we) sram0[if0.sram_addr] <= if0.sram_wdata;
         else             rd0 <= sram0[if0.sram_addr];
      end
      if (if1.sram_en) begin
         if (if1.sram_we) sram1[if1.sram_addr] <= if1.sram_wdata;
         else             rd1 <= sram1[if1.sram_addr];
      end
   end
   assign if0.sram_rdata = rd0;
   assign if1.sram_rdata = rd1;

   // Reference: the memory as an array of words, blocks are 8 aligned words
   logic [31:0] model [1024];
   int n_chk = 0;
   int n_fail = 0;

   function automatic logic [255:0] model_block(input logic [31:0] addr);
      logic [255:0] b;
      int unsigned bw;
      bw = (addr >> 5) << 3;
      for (int k = 0; k < 8; k++) b[k*32 +: 32] = model[(bw + k) & 1023];
      return b;
   endfunction

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One block transfer on dut0; entered and left at a negedge. Returns the
   // mem_ready cycle (request first high in cycle 0) and mem_rdata sampled in
   // the cycle after mem_ready, which is an IDLE cycle.
   task automatic xfer(input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [255:0] wd, input bit hold,
                       output int cyc, output logic [255:0] rdat);
      int unsigned bw;
      if0.mem_read = rd; if0.mem_write = wr; if0.mem_addr = addr; if0.mem_wdata = wd;
      cyc = -1;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (c == 1 && !hold) begin if0.mem_read = 1'b0; if0.mem_write = 1'b0; end
         if (if0.mem_ready) begin cyc = c; break; end
      end
      if0.mem_read = 1'b0; if0.mem_write = 1'b0;
      @(negedge clk);
      rdat = if0.mem_rdata;
      if (wr) begin
         bw = (addr >> 5) << 3;
         for (int k = 0; k < 8; k++) model[(bw + k) & 1023] = wd[k*32 +: 32];
      end
   endtask

   typedef struct {
      bit           rd;
      bit           wr;
      logic [31:0]  addr;
      logic [255:0] wdata;
      int           exp_cyc;
      bit           chk_rd;      // compare rdata with exp_rdata; else expect it unchanged
      logic [255:0] exp_rdata;
      bit           exp_perr;
   } vec_t;

   vec_t vecs [8];
   logic [255:0] blk_a, blk_b, blk_c, prev, rdat, exp_b;
   int cyc, first_en, first_busy, busy_cnt, rdy;
   bit exp_perr;

   initial begin
      for (int i = 0; i < 1024; i++) begin
         sram0[i] = 32'h5000_0000 | i; sram1[i] = 32'h5000_0000 | i; model[i] = 32'h5000_0000 | i;
      end
      for (int k = 0; k < 8; k++) begin
         blk_a[k*32 +: 32] = 32'hA000_0000 + k;
         blk_b[k*32 +: 32] = 32'hB000_0010 + k;
         blk_c[k*32 +: 32] = 32'hC000_0020 + k;
      end
      vecs[0] = '{1'b0, 1'b1, 32'h40, blk_a, 13, 1'b0, '0,    1'b0};
      vecs[1] = '{1'b1, 1'b0, 32'h40, '0,    14, 1'b1, blk_a, 1'b0};
      vecs[2] = '{1'b1, 1'b0, 32'h5C, '0,    14, 1'b1, blk_a, 1'b0};
      vecs[3] = '{1'b0, 1'b1, 32'h80, blk_b, 13, 1'b0, '0,    1'b0};  // writeback
      vecs[4] = '{1'b1, 1'b0, 32'h40, '0,    14, 1'b1, blk_a, 1'b0};  // allocate
      vecs[5] = '{1'b1, 1'b0, 32'h80, '0,    14, 1'b1, blk_b, 1'b0};
      vecs[6] = '{1'b1, 1'b1, 32'hC0, blk_c, 13, 1'b0, '0,    1'b1};  // collision
      vecs[7] = '{1'b1, 1'b0, 32'hC0, '0,    14, 1'b1, blk_c, 1'b1};

      {if0.mem_read, if0.mem_write, if0.mem_addr, if0.mem_wdata} = '0;
      {if1.mem_read, if1.mem_write, if1.mem_addr, if1.mem_wdata} = '0;
      repeat (3) @(negedge clk);
      chk("reset_busy",  256'(if0.busy), 256'(0));
      chk("reset_ready", 256'(if0.mem_ready), 256'(0));
      chk("reset_rdata", if0.mem_rdata, '0);
      chk("reset_perr",  256'(if0.proto_err), 256'(0));
      chk("reset_sram",  256'({if0.sram_en, if0.sram_we, if0.sram_addr, if0.sram_wdata}), 256'(0));
      rst_n = 1'b1;
      @(negedge clk);

      // LATENCY = 0 read of block 0 on dut1
      if1.mem_read = 1'b1; if1.mem_addr = 32'h0;
      first_en = -1; first_busy = -1; busy_cnt = 0; rdy = -1;
      for (int c = 1; c <= 14; c++) begin
         @(negedge clk);
         if (if1.sram_en && first_en < 0) first_en = c;
         if (if1.busy) begin busy_cnt++; if (first_busy < 0) first_busy = c; end
         if (if1.mem_ready) begin rdy = c; if1.mem_read = 1'b0; end
      end
      chk("lat0_first_en",   256'(first_en), 256'(1));
      chk("lat0_first_busy", 256'(first_busy), 256'(1));
      chk("lat0_busy_cnt",   256'(busy_cnt), 256'(10));
      chk("lat0_ready_cyc",  256'(rdy), 256'(10));
      for (int k = 0; k < 8; k++) exp_b[k*32 +: 32] = 32'h5000_0000 | k;
      chk("lat0_rdata", if1.mem_rdata, exp_b);

      // Directed table on dut0, issued back-to-back
      for (int i = 0; i < 8; i++) begin
         prev = if0.mem_rdata;
         chk($sformatf("vec%0d_idle_busy", i), 256'(if0.busy), 256'(0));
         xfer(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b1, cyc, rdat);
         chk($sformatf("vec%0d_ready_cyc", i), 256'(cyc), 256'(vecs[i].exp_cyc));
         chk($sformatf("vec%0d_rdata", i), rdat, vecs[i].chk_rd ? vecs[i].exp_rdata : prev);
         chk($sformatf("vec%0d_perr", i), 256'(if0.proto_err), 256'(vecs[i].exp_perr));
         if (i == 0)
            for (int k = 0; k < 8; k++)
               chk($sformatf("sram_word%0d", 16 + k), 256'(sram0[16 + k]), 256'(32'hA000_0000 + k));
      end

      // Reset during beat 3 of a read
      if0.mem_read = 1'b1; if0.mem_addr = 32'h80;
      cyc = -1;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (if0.sram_en && !if0.sram_we && if0.sram_addr[2:0] == 3'd3) begin cyc = c; break; end
      end
      chk("rst_beat3_cyc", 256'(cyc), 256'(8));
      rst_n = 1'b0;
      #1;
      chk("rst_busy",  256'(if0.busy), 256'(0));
      chk("rst_rdata", if0.mem_rdata, '0);
      chk("rst_perr",  256'(if0.proto_err), 256'(0));
      chk("rst_sram",  256'({if0.sram_en, if0.sram_we, if0.sram_addr, if0.sram_wdata}), 256'(0));
      if0.mem_read = 1'b0;
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      xfer(1'b1, 1'b0, 32'h40, '0, 1'b1, cyc, rdat);
      chk("post_rst_cyc", 256'(cyc), 256'(14));
      chk("post_rst_rdata", rdat, blk_a);

      // Random transfers against the word model
      exp_perr = 1'b0;
      for (int i = 0; i < 40; i++) begin
         int r;
         bit rd, wr, hold;
         logic [31:0] addr;
         logic [255:0] wd;
         r = $urandom_range(0, 9);
         wr = (r <= 4); rd = (r == 0) || (r >= 5);
         hold = 1'(($urandom_range(0, 1)));
         addr = $urandom;
         for (int k = 0; k < 8; k++) wd[k*32 +: 32] = $urandom;
         repeat ($urandom_range(0, 2)) @(negedge clk);
         prev = if0.mem_rdata;
         exp_b = model_block(addr);
         if (rd && wr) exp_perr = 1'b1;
         xfer(rd, wr, addr, wd, hold, cyc, rdat);
         chk($sformatf("rnd%0d_ready_cyc", i), 256'(cyc), 256'(wr ? 13 : 14));
         chk($sformatf("rnd%0d_rdata", i), rdat, wr ? prev : exp_b);
         chk($sformatf("rnd%0d_perr", i), 256'(if0.proto_err), 256'(exp_perr));
      end
      for (int k = 0; k < 1024; k += 37) chk($sformatf("final_sram%0d", k), 256'(sram0[k]), 256'(model[k]));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
